backlight_frame_tx: RTL

Consumer end of the block-mean pipeline: collects the per-frame stream of gamma-corrected block means (one byte per backlight zone, in raster block order) into a ping-pong buffer. At each frame boundary it ships the completed frame to the LED backlight driver over a write-only SPI link. Sits directly after the block-mean/gamma stage, in the same pixel-clock domain.

---
 rtl/backlight_frame_tx_if.sv | 33 +++
 rtl/backlight_frame_tx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/backlight_frame_tx_if.sv
// backlight_frame_tx_if
//   Bundles the block-mean input stream and the SPI/status outputs of
//   backlight_frame_tx into one interface.
//   Signals:
//     vs_i, mean_i[7:0], mean_valid_i     - frame sync and block-mean stream
//     spi_sclk, spi_mosi, spi_cs_n        - write-only SPI link to LED driver
//     busy_o, err_short_o, err_over_o,
//     drop_o                              - transfer status and error pulses
//   Modports:
//     slave  - the frame transmitter (consumes stream, drives SPI/status)
//     master - the upstream stage / bench (drives stream, observes SPI/status)
interface backlight_frame_tx_if;
  logic       vs_i;
  logic [7:0] mean_i;
  logic       mean_valid_i;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_cs_n;
  logic       busy_o;
  logic       err_short_o;
  logic       err_over_o;
  logic       drop_o;

  modport slave (
    input  vs_i, mean_i, mean_valid_i,
    output spi_sclk, spi_mosi, spi_cs_n, busy_o, err_short_o, err_over_o, drop_o
  );

  modport master (
    output vs_i, mean_i, mean_valid_i,
    input  spi_sclk, spi_mosi, spi_cs_n, busy_o, err_short_o, err_over_o, drop_o
  );
endinterface

// File: rtl/backlight_frame_tx.sv
// backlight_frame_tx
//   Collects one byte per backlight zone into a ping-pong buffer and, at each
//   frame-sync rising edge, ships the completed frame over SPI (mode 0, MSB
//   first) as HEADER, BLOCK_NUM data bytes, then an 8-bit additive checksum.
//   Ports:
//     clk   - pixel clock
//     rstn  - asynchronous active-low reset
//     bus   - backlight_frame_tx_if.slave: vs_i, mean_i, mean_valid_i in;
//             spi_sclk, spi_mosi, spi_cs_n, busy_o, err_short_o, err_over_o,
//             drop_o out (all outputs registered)
module backlight_frame_tx #(
  parameter int         BLOCK_NUM = 128,
  parameter int         CLK_DIV   = 4,
  parameter logic [7:0] HEADER    = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rstn,
  backlight_frame_tx_if.slave   bus
);

  localparam int CW = $clog2(BLOCK_NUM + 1);
  localparam int BW = $clog2(BLOCK_NUM + 2);
  localparam int IW = $clog2(2 * BLOCK_NUM);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  // Both banks live in one array: bank b occupies [b*BLOCK_NUM +: BLOCK_NUM].
  logic [7:0]    mem_r [0:2*BLOCK_NUM-1];
  logic [7:0]    rd_data_r;

  logic          vs_d_r;
  logic          bank_sel_r;
  logic [CW-1:0] wr_cnt_r;
  logic          over_r;

  logic          boundary_s;
  logic          frame_full_s;
  logic          start_s;
  logic          err_short_s;
  logic          err_over_s;
  logic          drop_s;
  logic          wr_en_s;
  logic          wr_bank_s;
  logic [IW-1:0] wr_idx_s;
  logic [IW-1:0] rd_idx_s;

  logic          err_short_req_r;
  logic          err_over_req_r;
  logic          drop_req_r;

  state_t        state_r;
  state_t        state_n;
  logic [DW-1:0] div_cnt_r;
  logic          phase_r;
  logic [2:0]    bit_cnt_r;
  logic [BW-1:0] byte_cnt_r;
  logic [7:0]    sh_r;
  logic [7:0]    sum_r;

  logic          div_last_s;
  logic          bit_end_s;
  logic          byte_end_s;
  logic          last_byte_s;
  logic          cs_n_s;
  logic          busy_s;
  logic          sclk_s;
  logic          mosi_s;

  logic          spi_sclk_r;
  logic          spi_mosi_r;
  logic          spi_cs_n_r;
  logic          busy_r;
  logic          err_short_r;
  logic          err_over_r;
  logic          drop_r;

  // Frame-boundary classification, judged on the counts held before this cycle.
  always_comb begin
    boundary_s   = bus.vs_i & ~vs_d_r;
    frame_full_s = (wr_cnt_r == CW'(BLOCK_NUM));
    start_s      = 1'b0;
    err_short_s  = 1'b0;
    err_over_s   = 1'b0;
    drop_s       = 1'b0;
    if (boundary_s) begin
      if (over_r) begin
        err_over_s = 1'b1;
      end else if (wr_cnt_r == CW'(0)) begin
        err_short_s = 1'b0;  // empty frame: nothing to report
      end else if (!frame_full_s) begin
        err_short_s = 1'b1;
      end else if (state_r == ST_IDLE) begin
        start_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      start_s = 1'b0;
    end
  end

  // Write address; a sample in the boundary cycle lands at entry 0 of the
  // bank that will be written next (the other one if this boundary swaps).
  always_comb begin
    wr_bank_s = start_s ? ~bank_sel_r : bank_sel_r;
    wr_en_s   = 1'b0;
    wr_idx_s  = (wr_bank_s ? IW'(BLOCK_NUM) : IW'(0)) +
                (boundary_s ? IW'(0) : IW'(wr_cnt_r));
    if (bus.mean_valid_i) begin
      if (boundary_s) begin
        wr_en_s = 1'b1;
      end else if (!frame_full_s) begin
        wr_en_s = 1'b1;
      end else begin
        wr_en_s = 1'b0;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Read address: while byte n is on the wire, fetch data[n] for byte n+1.
  always_comb begin
    rd_idx_s = bank_sel_r ? IW'(0) : IW'(BLOCK_NUM);
    if (byte_cnt_r < BW'(BLOCK_NUM)) begin
      rd_idx_s = rd_idx_s + IW'(byte_cnt_r);
    end else begin
      rd_idx_s = rd_idx_s;
    end
  end

  // Frame buffer storage with synchronous read; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_idx_s] <= bus.mean_i;
    end
    rd_data_r <= mem_r[rd_idx_s];
  end

  // Write-side bookkeeping: sample count, overflow flag, bank select.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_d_r          <= 1'b0;
      bank_sel_r      <= 1'b0;
      wr_cnt_r        <= CW'(0);
      over_r          <= 1'b0;
      err_short_req_r <= 1'b0;
      err_over_req_r  <= 1'b0;
      drop_req_r      <= 1'b0;
    end else begin
      vs_d_r          <= bus.vs_i;
      err_short_req_r <= err_short_s;
      err_over_req_r  <= err_over_s;
      drop_req_r      <= drop_s;
      if (boundary_s) begin
        wr_cnt_r <= bus.mean_valid_i ? CW'(1) : CW'(0);
        over_r   <= 1'b0;
        if (start_s) begin
          bank_sel_r <= ~bank_sel_r;
        end
      end else if (bus.mean_valid_i) begin
        if (frame_full_s) begin
          over_r <= 1'b1;
        end else begin
          wr_cnt_r <= wr_cnt_r + CW'(1);
        end
      end
    end
  end

  // TX state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // TX next-state and pre-register output values.
  always_comb begin
    div_last_s  = (div_cnt_r == DW'(CLK_DIV - 1));
    bit_end_s   = (state_r == ST_SHIFT) && phase_r && div_last_s;
    byte_end_s  = bit_end_s && (bit_cnt_r == 3'd7);
    last_byte_s = (byte_cnt_r == BW'(BLOCK_NUM + 1));
    state_n     = state_r;
    case (state_r)
      ST_IDLE:  state_n = start_s ? ST_SETUP : ST_IDLE;
      ST_SETUP: state_n = div_last_s ? ST_SHIFT : ST_SETUP;
      ST_SHIFT: state_n = (byte_end_s && last_byte_s) ? ST_HOLD : ST_SHIFT;
      ST_HOLD:  state_n = div_last_s ? ST_GAP : ST_HOLD;
      ST_GAP:   state_n = div_last_s ? ST_IDLE : ST_GAP;
      default:  state_n = ST_IDLE;
    endcase
    cs_n_s = !((state_r == ST_SETUP) || (state_r == ST_SHIFT) || (state_r == ST_HOLD));
    busy_s = (state_r != ST_IDLE);
    sclk_s = (state_r == ST_SHIFT) && phase_r;
    mosi_s = (state_r == ST_SHIFT) ? sh_r[7] : 1'b0;
  end

  // Bit timing, byte sequencing, shift register and running checksum.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt_r  <= DW'(0);
      phase_r    <= 1'b0;
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= BW'(0);
      sh_r       <= 8'd0;
      sum_r      <= 8'd0;
    end else if (state_r == ST_IDLE) begin
      div_cnt_r  <= DW'(0);
      phase_r    <= 1'b0;
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= BW'(0);
    end else begin
      div_cnt_r <= div_last_s ? DW'(0) : div_cnt_r + DW'(1);
      if (state_r == ST_SETUP) begin
        phase_r    <= 1'b0;
        bit_cnt_r  <= 3'd0;
        byte_cnt_r <= BW'(0);
        if (div_last_s) begin
          sh_r  <= HEADER;
          sum_r <= 8'd0;
        end
      end else if (state_r == ST_SHIFT) begin
        if (div_last_s) begin
          phase_r <= ~phase_r;
        end
        if (bit_end_s) begin
          if (bit_cnt_r == 3'd7) begin
            bit_cnt_r  <= 3'd0;
            byte_cnt_r <= byte_cnt_r + BW'(1);
            // Next byte index is byte_cnt+1: data while <= BLOCK_NUM, then checksum.
            if (byte_cnt_r < BW'(BLOCK_NUM)) begin
              sh_r  <= rd_data_r;
              sum_r <= csum_add(sum_r, rd_data_r);
            end else begin
              sh_r <= sum_r;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + 3'd1;
            sh_r      <= {sh_r[6:0], 1'b0};
          end
        end
      end else begin
        phase_r <= 1'b0;
      end
    end
  end

  // Registered outputs; every output lags the FSM by one cycle uniformly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      spi_sclk_r  <= 1'b0;
      spi_mosi_r  <= 1'b0;
      spi_cs_n_r  <= 1'b1;
      busy_r      <= 1'b0;
      err_short_r <= 1'b0;
      err_over_r  <= 1'b0;
      drop_r      <= 1'b0;
    end else begin
      spi_sclk_r  <= sclk_s;
      spi_mosi_r  <= mosi_s;
      spi_cs_n_r  <= cs_n_s;
      busy_r      <= busy_s;
      err_short_r <= err_short_req_r;
      err_over_r  <= err_over_req_r;
      drop_r      <= drop_req_r;
    end
  end

  assign bus.spi_sclk    = spi_sclk_r;
  assign bus.spi_mosi    = spi_mosi_r;
  assign bus.spi_cs_n    = spi_cs_n_r;
  assign bus.busy_o      = busy_r;
  assign bus.err_short_o = err_short_r;
  assign bus.err_over_o  = err_over_r;
  assign bus.drop_o      = drop_r;

endmodule
